stepdir_phase_decoder: RTL and testbench
========================================

Name: stepdir_phase_decoder

Overview:
Receives STEP/DIR pulse trains from an external motion controller and turns them into the fixed-point electrical phase (Q_WIDTH fractional bits) consumed by the microstep PWM controller. Each accepted step advances or retracts an internal phase accumulator by a programmable microstep increment. The output phase is re-latched only on the PWM controller's update strobe, so it changes only at PWM period boundaries. The block also keeps a signed step position counter and sticky timing-error flags.

Parameters:
PHASE_WIDTH, 32, width of phase accumulator and phase output
Q_WIDTH, 16, fractional bits of phase; 1<<Q_WIDTH = one full step
SHIFT_WIDTH, 5, width of step_shift
FILTER_WIDTH, 8, width of glitch filter counter and filter_cycles
SETUP_CYCLES, 8, minimum DIR-stable cycles required before a STEP rising edge
POSITION_WIDTH, 32, width of signed position counter
MAX_STEPS, 16, maximum steps allowed between two update strobes

Ports:
clk  in  1  system clock
aresetn  in  1  asynchronous active-low reset
enable  in  1  1 = accept steps; 0 = ignore step events
step_shift  in  SHIFT_WIDTH  microstep resolution; increment = 1<<(Q_WIDTH-min(step_shift,Q_WIDTH))
filter_cycles  in  FILTER_WIDTH  extra stable cycles required by glitch filter
dir_invert  in  1  inverts DIR sense
in_step  in  1  asynchronous STEP pin
in_dir  in  1  asynchronous DIR pin (1 = forward)
update  in  1  one-cycle strobe from PWM controller (end of PWM period)
phase  out  PHASE_WIDTH  phase latched at last update
position  out  POSITION_WIDTH  signed accepted-step count, two's-complement wrap
step_valid  out  1  one-cycle pulse per accepted step
err_dir_setup  out  1  sticky: DIR changed less than SETUP_CYCLES before step edge
err_overrun  out  1  sticky: more than MAX_STEPS steps in one update interval
err_clear  in  1  clears both sticky flags

Behaviour:
- Reset (aresetn=0, async): all registers 0. phase=0, position=0, step_valid=0, both err=0, filtered levels=0, sync FFs=0.
- in_step and in_dir each pass through a 2-FF synchronizer, then a glitch filter. Filter counter counts cycles where sync≠filtered level. It clears when they match. When sync≠filtered and counter==filter_cycles, filtered level <= sync and counter <= 0. A change therefore needs filter_cycles+1 consecutive differing samples.
- Step event: filtered STEP rises (0→1) while enable=1. Falling edges are ignored. With enable=0, filters still run, but events are dropped and counters do not move.
- Effective direction = filtered DIR XOR dir_invert, sampled in the event cycle.
- Accumulator acc: forward adds increment, reverse subtracts. Arithmetic is modulo 2^PHASE_WIDTH. step_shift > Q_WIDTH clamps to Q_WIDTH, giving increment 1.
- On each event, registered at the next edge: acc, position ±1 and step_valid=1 all in the same cycle. With filter_cycles=0, step_valid rises on the 4th clk edge after in_step rises, counting synchronizer and filter stages.
- DIR setup: a dir-stable counter resets on every filtered DIR change and saturates at SETUP_CYCLES. If an event occurs with the counter < SETUP_CYCLES, err_dir_setup is set. The step is still applied with the new direction.
- Update: on update=1, phase <= acc value before any step applied in that same cycle. Latency is 1 cycle. phase holds otherwise.
- Interval step counter: it increments per event and saturates at MAX_STEPS+1. Update loads it with 1 if an event occurs in the same cycle, else 0. If an event takes the counter past MAX_STEPS, err_overrun is set.
- err_clear is synchronous. A set condition in the same cycle wins over err_clear.
- step_shift, dir_invert and filter_cycles may change at any time. They take effect on the next event or sample; no pipeline flush is needed.

Test Plan:
- Reset, enable=1, step_shift=4, filter_cycles=0, dir=1, 3 clean step pulses (4 clk high/4 low), then update → acc=0x3000, phase=0x00003000 one cycle after update, position=3, three step_valid pulses.
- From reset, dir=0, 5 steps, update → phase=0xFFFFB000, position=-5 (0xFFFFFFFB). Repeat with dir_invert=1 → phase=0x00005000, position=5.
- filter_cycles=3, 2-cycle STEP glitch, then a 6-cycle pulse → exactly one step_valid. The glitch produces no acc change.
- DIR toggled 3 cycles before the STEP edge (SETUP_CYCLES=8) → err_dir_setup=1, step applied with new direction. err_clear → 0. err_clear asserted in the same cycle as a new violation → flag stays 1.
- MAX_STEPS=16, 17 steps with no update → err_overrun=1 on the 17th step. Update coinciding with a step event → phase excludes that step, and the interval count restarts at 1.
- Deassert aresetn mid-pulse-train, between step_valid and update → phase, position, acc and errors read 0 immediately. The next step after release yields position=1.

Source files
------------

// File: rtl/stepdir_phase_decoder_if.sv
// Bundles the control, pin and status signals of the STEP/DIR phase decoder.
//   master : drives the pins, configuration, update strobe and err_clear
//   slave  : the decoder; returns phase, position, step_valid and error flags
interface stepdir_phase_decoder_if #(
  parameter int PHASE_WIDTH    = 32,
  parameter int SHIFT_WIDTH    = 5,
  parameter int FILTER_WIDTH   = 8,
  parameter int POSITION_WIDTH = 32
);
  logic                      enable;
  logic [SHIFT_WIDTH-1:0]    step_shift;
  logic [FILTER_WIDTH-1:0]   filter_cycles;
  logic                      dir_invert;
  logic                      in_step;
  logic                      in_dir;
  logic                      update;
  logic                      err_clear;
  logic [PHASE_WIDTH-1:0]    phase;
  logic [POSITION_WIDTH-1:0] position;
  logic                      step_valid;
  logic                      err_dir_setup;
  logic                      err_overrun;

  modport master (
    output enable, step_shift, filter_cycles, dir_invert, in_step, in_dir,
           update, err_clear,
    input  phase, position, step_valid, err_dir_setup, err_overrun
  );

  modport slave (
    input  enable, step_shift, filter_cycles, dir_invert, in_step, in_dir,
           update, err_clear,
    output phase, position, step_valid, err_dir_setup, err_overrun
  );
endinterface

// File: rtl/stepdir_phase_decoder.sv
// STEP/DIR to electrical phase decoder.
// Synchronizes and glitch-filters the STEP/DIR pins, advances a fixed-point
// phase accumulator by a microstep increment on every accepted STEP rising
// edge, and re-latches the published phase only on the PWM update strobe.
// Ports:
//   clk, aresetn : system clock, asynchronous active-low reset
//   bus (slave)  : enable, step_shift, filter_cycles, dir_invert, in_step,
//                  in_dir, update, err_clear in; phase, position, step_valid,
//                  err_dir_setup, err_overrun out
module stepdir_phase_decoder #(
  parameter int PHASE_WIDTH    = 32,
  parameter int Q_WIDTH        = 16,
  parameter int SHIFT_WIDTH    = 5,
  parameter int FILTER_WIDTH   = 8,
  parameter int SETUP_CYCLES   = 8,
  parameter int POSITION_WIDTH = 32,
  parameter int MAX_STEPS      = 16
) (
  input logic                  clk,
  input logic                  aresetn,
  stepdir_phase_decoder_if.slave bus
);
  localparam int SETUP_W = $clog2(SETUP_CYCLES + 1);
  localparam int CNT_W   = $clog2(MAX_STEPS + 2);

  logic step_s1_q, step_s1_d, step_s2_q, step_s2_d;
  logic dir_s1_q, dir_s1_d, dir_s2_q, dir_s2_d;
  logic step_filt_q, step_filt_d, dir_filt_q, dir_filt_d;
  logic step_prev_q, step_prev_d;
  logic [FILTER_WIDTH-1:0]   step_fcnt_q, step_fcnt_d, dir_fcnt_q, dir_fcnt_d;
  logic [SETUP_W-1:0]        dir_stable_q, dir_stable_d;
  logic [PHASE_WIDTH-1:0]    acc_q, acc_d, phase_q, phase_d;
  logic [POSITION_WIDTH-1:0] position_q, position_d;
  logic                      step_valid_q, step_valid_d;
  logic [CNT_W-1:0]          interval_q, interval_d;
  logic                      err_setup_q, err_setup_d, err_overrun_q, err_overrun_d;

  logic                      step_event, dir_fwd, setup_viol, overrun_set;
  logic [SHIFT_WIDTH-1:0]    shift_eff;
  logic [PHASE_WIDTH-1:0]    incr;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      step_s1_q     <= 1'b0;
      step_s2_q     <= 1'b0;
      dir_s1_q      <= 1'b0;
      dir_s2_q      <= 1'b0;
      step_filt_q   <= 1'b0;
      dir_filt_q    <= 1'b0;
      step_prev_q   <= 1'b0;
      step_fcnt_q   <= '0;
      dir_fcnt_q    <= '0;
      dir_stable_q  <= '0;
      acc_q         <= '0;
      phase_q       <= '0;
      position_q    <= '0;
      step_valid_q  <= 1'b0;
      interval_q    <= '0;
      err_setup_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      step_s1_q     <= step_s1_d;
      step_s2_q     <= step_s2_d;
      dir_s1_q      <= dir_s1_d;
      dir_s2_q      <= dir_s2_d;
      step_filt_q   <= step_filt_d;
      dir_filt_q    <= dir_filt_d;
      step_prev_q   <= step_prev_d;
      step_fcnt_q   <= step_fcnt_d;
      dir_fcnt_q    <= dir_fcnt_d;
      dir_stable_q  <= dir_stable_d;
      acc_q         <= acc_d;
      phase_q       <= phase_d;
      position_q    <= position_d;
      step_valid_q  <= step_valid_d;
      interval_q    <= interval_d;
      err_setup_q   <= err_setup_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  always_comb begin
    step_s1_d = bus.in_step;
    step_s2_d = step_s1_q;
    dir_s1_d  = bus.in_dir;
    dir_s2_d  = dir_s1_q;

    // Glitch filters: a level change needs filter_cycles+1 consecutive
    // differing samples. '>=' keeps a lowered filter_cycles from stranding
    // a counter that is already above the new limit.
    step_filt_d = step_filt_q;
    step_fcnt_d = '0;
    if (step_s2_q != step_filt_q) begin
      if (step_fcnt_q >= bus.filter_cycles) step_filt_d = step_s2_q;
      else                                  step_fcnt_d = step_fcnt_q + FILTER_WIDTH'(1);
    end
    dir_filt_d = dir_filt_q;
    dir_fcnt_d = '0;
    if (dir_s2_q != dir_filt_q) begin
      if (dir_fcnt_q >= bus.filter_cycles) dir_filt_d = dir_s2_q;
      else                                 dir_fcnt_d = dir_fcnt_q + FILTER_WIDTH'(1);
    end

    step_prev_d = step_filt_q;
    step_event  = bus.enable & step_filt_q & ~step_prev_q;
    dir_fwd     = dir_filt_q ^ bus.dir_invert;

    // Counts cycles since the filtered DIR level last moved.
    dir_stable_d = dir_stable_q;
    if (dir_filt_d != dir_filt_q)                   dir_stable_d = '0;
    else if (dir_stable_q < SETUP_W'(SETUP_CYCLES)) dir_stable_d = dir_stable_q + SETUP_W'(1);
    setup_viol = step_event & (dir_stable_q < SETUP_W'(SETUP_CYCLES));

    shift_eff = (bus.step_shift > SHIFT_WIDTH'(Q_WIDTH)) ? SHIFT_WIDTH'(Q_WIDTH) : bus.step_shift;
    incr      = PHASE_WIDTH'(1) << (SHIFT_WIDTH'(Q_WIDTH) - shift_eff);

    acc_d        = acc_q;
    position_d   = position_q;
    step_valid_d = step_event;
    if (step_event) begin
      acc_d      = dir_fwd ? acc_q + incr : acc_q - incr;
      position_d = dir_fwd ? position_q + POSITION_WIDTH'(1) : position_q - POSITION_WIDTH'(1);
    end

    // Published phase excludes a step landing in the update cycle itself.
    phase_d = bus.update ? acc_q : phase_q;

    overrun_set = 1'b0;
    interval_d  = interval_q;
    if (bus.update) begin
      interval_d  = step_event ? CNT_W'(1) : '0;
      overrun_set = step_event && (MAX_STEPS == 0);
    end else if (step_event) begin
      if (interval_q >= CNT_W'(MAX_STEPS)) begin
        interval_d  = CNT_W'(MAX_STEPS + 1);
        overrun_set = 1'b1;
      end else begin
        interval_d  = interval_q + CNT_W'(1);
      end
    end

    // A new violation outranks a simultaneous clear.
    err_setup_d   = setup_viol  ? 1'b1 : (bus.err_clear ? 1'b0 : err_setup_q);
    err_overrun_d = overrun_set ? 1'b1 : (bus.err_clear ? 1'b0 : err_overrun_q);
  end

  assign bus.phase         = phase_q;
  assign bus.position      = position_q;
  assign bus.step_valid    = step_valid_q;
  assign bus.err_dir_setup = err_setup_q;
  assign bus.err_overrun   = err_overrun_q;
endmodule

// File: tb/tb_stepdir_phase_decoder.sv
// Self-checking bench for stepdir_phase_decoder: vector table of clean step
// trains, hand sequences for latency/filter/setup/overrun/reset corners, and
// a randomized run against a step-counting arithmetic model.
module tb_stepdir_phase_decoder;
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  stepdir_phase_decoder_if bus ();
  stepdir_phase_decoder dut (.clk(clk), .aresetn(aresetn), .bus(bus));

  int n_checks = 0;
  int n_err    = 0;
  int sv_cnt   = 0;

  always @(negedge clk) if (bus.step_valid === 1'b1) sv_cnt++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input int hi, input int lo);
    bus.in_step = 1'b1; tick(hi);
    bus.in_step = 1'b0; tick(lo);
  endtask

  task automatic do_update();
    bus.update = 1'b1; tick(1);
    bus.update = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    bus.enable = 1'b1; bus.step_shift = 5'd4; bus.filter_cycles = 8'd0;
    bus.dir_invert = 1'b0; bus.in_step = 1'b0; bus.in_dir = 1'b0;
    bus.update = 1'b0; bus.err_clear = 1'b0;
    tick(2);
    aresetn = 1'b1;
    tick(1);
    sv_cnt = 0;
  endtask

  typedef struct {
    logic        dir;
    logic        inv;
    logic [4:0]  shift;
    int          n;
    logic [31:0] exp_phase;
    logic [31:0] exp_pos;
  } vec_t;
  vec_t vt[7];

  logic [31:0] m_acc, m_pos, m_inc;
  int          m_sv, shv, fl, hi, lo;
  logic        d, inv, en;

  initial begin
    vt[0] = '{1'b1, 1'b0, 5'd4,  3, 32'h0000_3000, 32'd3};
    vt[1] = '{1'b0, 1'b0, 5'd4,  5, 32'hFFFF_B000, 32'hFFFF_FFFB};
    vt[2] = '{1'b0, 1'b1, 5'd4,  5, 32'h0000_5000, 32'd5};
    vt[3] = '{1'b1, 1'b0, 5'd0,  2, 32'h0002_0000, 32'd2};
    vt[4] = '{1'b1, 1'b1, 5'd20, 4, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vt[5] = '{1'b1, 1'b0, 5'd16, 1, 32'h0000_0001, 32'd1};
    vt[6] = '{1'b0, 1'b0, 5'd16, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    // Reset state
    do_reset();
    check("rst_phase", bus.phase, 32'd0);
    check("rst_position", bus.position, 32'd0);
    check("rst_flags", {29'd0, bus.step_valid, bus.err_dir_setup, bus.err_overrun}, 32'd0);

    // Step-to-step_valid latency with filter_cycles=0
    bus.in_dir = 1'b1; tick(16);
    bus.in_step = 1'b1; tick(3);
    check("lat_edge3", {31'd0, bus.step_valid}, 32'd0);
    tick(1);
    check("lat_edge4", {31'd0, bus.step_valid}, 32'd1);
    bus.in_step = 1'b0; tick(4);

    // Vector table
    foreach (vt[i]) begin
      do_reset();
      bus.in_dir = vt[i].dir; bus.dir_invert = vt[i].inv; bus.step_shift = vt[i].shift;
      tick(16);
      for (int k = 0; k < vt[i].n; k++) pulse(4, 4);
      tick(4);
      check($sformatf("vec%0d_sv", i), sv_cnt, vt[i].n);
      check($sformatf("vec%0d_phase_hold", i), bus.phase, 32'd0);
      do_update();
      check($sformatf("vec%0d_phase", i), bus.phase, vt[i].exp_phase);
      check($sformatf("vec%0d_pos", i), bus.position, vt[i].exp_pos);
    end

    // Glitch filter
    do_reset();
    bus.filter_cycles = 8'd3; bus.in_dir = 1'b1; tick(16);
    bus.in_step = 1'b1; tick(2);
    bus.in_step = 1'b0; tick(10);
    check("glitch_sv", sv_cnt, 0);
    do_update();
    check("glitch_phase", bus.phase, 32'd0);
    pulse(6, 10);
    check("pulse6_sv", sv_cnt, 1);
    do_update();
    check("pulse6_phase", bus.phase, 32'h1000);

    // DIR setup violation and err_clear priority
    do_reset();
    bus.in_dir = 1'b1; tick(16);
    pulse(4, 4);
    check("setup_clean", {31'd0, bus.err_dir_setup}, 32'd0);
    bus.in_dir = 1'b0; tick(3);
    pulse(4, 4);
    check("setup_viol", {31'd0, bus.err_dir_setup}, 32'd1);
    do_update();
    check("setup_phase", bus.phase, 32'd0);
    check("setup_pos", bus.position, 32'd0);
    bus.err_clear = 1'b1; tick(1); bus.err_clear = 1'b0;
    check("setup_clear", {31'd0, bus.err_dir_setup}, 32'd0);
    bus.in_dir = 1'b1; tick(3);
    bus.in_step = 1'b1; tick(3);
    bus.err_clear = 1'b1; tick(1); bus.err_clear = 1'b0;
    tick(1); bus.in_step = 1'b0; tick(4);
    check("setup_set_wins", {31'd0, bus.err_dir_setup}, 32'd1);
    do_update();
    check("setup_phase2", bus.phase, 32'h1000);

    // Overrun and update coinciding with a step
    do_reset();
    bus.step_shift = 5'd16; bus.in_dir = 1'b1; tick(16);
    repeat (16) pulse(2, 2);
    tick(4);
    check("ovr_16", {31'd0, bus.err_overrun}, 32'd0);
    pulse(2, 2); tick(4);
    check("ovr_17", {31'd0, bus.err_overrun}, 32'd1);
    bus.err_clear = 1'b1; tick(1); bus.err_clear = 1'b0;
    check("ovr_clear", {31'd0, bus.err_overrun}, 32'd0);
    do_update();
    check("ovr_phase17", bus.phase, 32'd17);
    bus.in_step = 1'b1; tick(3);
    bus.update = 1'b1; tick(1); bus.update = 1'b0;
    bus.in_step = 1'b0; tick(4);
    check("coinc_phase", bus.phase, 32'd17);
    repeat (15) pulse(2, 2);
    tick(4);
    check("coinc_cnt16", {31'd0, bus.err_overrun}, 32'd0);
    pulse(2, 2); tick(4);
    check("coinc_cnt17", {31'd0, bus.err_overrun}, 32'd1);
    do_update();
    check("coinc_phase34", bus.phase, 32'd34);

    // Asynchronous reset mid-train
    do_reset();
    bus.in_dir = 1'b1; tick(16);
    pulse(4, 4); pulse(4, 4);
    do_update();
    check("arst_pre_phase", bus.phase, 32'h2000);
    bus.in_dir = 1'b0; tick(3);
    pulse(4, 2);
    check("arst_pre_err", {31'd0, bus.err_dir_setup}, 32'd1);
    check("arst_pre_pos", bus.position, 32'd1);
    #2 aresetn = 1'b0;
    #1;
    check("arst_phase", bus.phase, 32'd0);
    check("arst_pos", bus.position, 32'd0);
    check("arst_err", {30'd0, bus.err_dir_setup, bus.err_overrun}, 32'd0);
    bus.in_dir = 1'b1;
    #3 aresetn = 1'b1;
    tick(16);
    pulse(4, 4); tick(4);
    check("arst_next_pos", bus.position, 32'd1);
    do_update();
    check("arst_next_phase", bus.phase, 32'h1000);

    // Randomized run against an arithmetic step model
    do_reset();
    m_acc = '0; m_pos = '0; m_sv = 0;
    for (int t = 0; t < 60; t++) begin
      shv = $urandom_range(0, 20);
      d   = 1'($urandom_range(0, 1));
      inv = 1'($urandom_range(0, 1));
      fl  = $urandom_range(0, 2);
      en  = ($urandom_range(0, 4) != 0);
      bus.step_shift = 5'(shv); bus.in_dir = d; bus.dir_invert = inv;
      bus.filter_cycles = 8'(fl); bus.enable = en;
      tick(14 + fl);
      hi = $urandom_range(fl + 1, fl + 4);
      lo = $urandom_range(fl + 1, fl + 4);
      pulse(hi, lo);
      tick(6);
      if (en) begin
        m_inc = 32'd1 << (16 - ((shv > 16) ? 16 : shv));
        if (d != inv) begin m_acc = m_acc + m_inc; m_pos = m_pos + 1; end
        else          begin m_acc = m_acc - m_inc; m_pos = m_pos - 1; end
        m_sv++;
      end
      if ($urandom_range(0, 3) == 0) begin
        do_update();
        check($sformatf("rnd%0d_phase", t), bus.phase, m_acc);
      end
    end
    do_update();
    check("rnd_final_phase", bus.phase, m_acc);
    check("rnd_final_pos", bus.position, m_pos);
    check("rnd_final_sv", sv_cnt, m_sv);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
